multi_button_debouncer: RTL and testbench

Parametrised N-channel debouncer that replaces the single-button, slow-clock debouncer in the game-logic input path. All channels run on `CLOCK_50` and share one tick prescaler, so there is no derived clock. Each channel has a two-flop synchroniser, polarity normalisation and a stability counter. Per channel, the block produces a clean level plus one-cycle press and release strobes for the blackjack control FSM (hit/stand/deal), with optional hold-to-repeat.

---
 rtl/multi_button_debouncer.sv | 151 +++++++++++++++
 tb/tb_multi_button_debouncer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/multi_button_debouncer.sv
// -----------------------------------------------------------------------------
// multi_button_debouncer
//
// N-channel push-button debouncer running entirely on CLOCK_50. A single
// shared prescaler produces a one-cycle sample tick every TICK_DIV cycles.
// Each channel synchronises its raw pin, normalises polarity so that 1 means
// "pressed", and accepts a new level only after STABLE_TICKS consecutive
// ticks of disagreement with the current debounced level.
//
// Ports:
//   CLOCK_50     in   1         system clock
//   resetn       in   1         asynchronous active-low reset
//   btn_in       in   CHANNELS  raw asynchronous button pins
//   btn_level    out  CHANNELS  debounced level, 1 = pressed
//   btn_press    out  CHANNELS  one-cycle strobe on accepted press (and repeat)
//   btn_release  out  CHANNELS  one-cycle strobe on accepted release
//
// Optional feature: define DEBOUNCE_AUTOREPEAT_EN to add hold-to-repeat press
// strobes (first after REPEAT_DELAY ticks, then every REPEAT_RATE ticks).
// -----------------------------------------------------------------------------
module multi_button_debouncer #(
  parameter int CHANNELS     = 4,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(STABLE_TICKS + 1);

  localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_TICKS - 1);
  localparam logic          RAW_IDLE    = (ACTIVE_LOW != 0);

  logic [CHANNELS-1:0] sync1, sync2, norm;
  logic [PW-1:0]       presc;
  logic                tick;
  logic [SW-1:0]       stab_cnt [CHANNELS];
  logic [CHANNELS-1:0] accept;      // final qualifying tick of a disagreement
  logic [CHANNELS-1:0] rep_strobe;  // hold-to-repeat press strobes

  // Synchroniser: resets to the idle raw value so an idle button does not
  // look like a press on the first cycles after reset.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sync1 <= {CHANNELS{RAW_IDLE}};
      sync2 <= {CHANNELS{RAW_IDLE}};
    end else begin
      // NOTE: non-blocking assignments make sync2 take the previous sync1,
      // giving two real flop stages; blocking would collapse them into one.
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  assign norm = sync2 ^ {CHANNELS{RAW_IDLE}};

  // Shared sample-tick prescaler.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)                 presc <= '0;
    else if (presc == PRESC_LAST) presc <= '0;
    else                         presc <= presc + 1'b1;
  end

  assign tick = (presc == PRESC_LAST);

  always_comb begin
    // NOTE: default first so every path assigns accept and no latch is inferred.
    accept = '0;
    for (int i = 0; i < CHANNELS; i++)
      accept[i] = (norm[i] != btn_level[i]) && tick && (stab_cnt[i] == STABLE_LAST);
  end

  // Stability counters and registered outputs. An agreeing input clears the
  // counter on any cycle, so a disagreement that ends on the final tick is
  // discarded rather than accepted.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the per-channel counter array is explicitly reset; it is a small
      // register bank, and an unknown start count could accept a level early.
      for (int i = 0; i < CHANNELS; i++) stab_cnt[i] <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (norm[i] == btn_level[i])  stab_cnt[i] <= '0;
        else if (accept[i])           stab_cnt[i] <= '0;
        else if (tick)                stab_cnt[i] <= stab_cnt[i] + 1'b1;
      end
      btn_level   <= btn_level ^ accept;
      btn_press   <= (accept & ~btn_level) | rep_strobe;
      btn_release <= accept & btn_level;
    end
  end

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [RW-1:0] REP_DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic [RW-1:0]       rep_cnt [CHANNELS];
  logic [CHANNELS-1:0] rep_phase;  // 0: waiting for first repeat, 1: steady rate

  // A repeat fires on the tick that completes the current interval, but never
  // on the tick that accepts a release.
  always_comb begin
    rep_strobe = '0;
    for (int i = 0; i < CHANNELS; i++)
      rep_strobe[i] = btn_level[i] && tick && !accept[i] &&
                      (rep_cnt[i] == (rep_phase[i] ? REP_RATE_LAST : REP_DELAY_LAST));
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < CHANNELS; i++) rep_cnt[i] <= '0;
      rep_phase <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!btn_level[i] || accept[i]) begin
          rep_cnt[i]   <= '0;
          rep_phase[i] <= 1'b0;
        end else if (rep_strobe[i]) begin
          rep_cnt[i]   <= '0;
          rep_phase[i] <= 1'b1;
        end else if (tick) begin
          rep_cnt[i]   <= rep_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign rep_strobe = '0;

  // Keeps the repeat parameters referenced in builds without repeat logic.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
`endif

endmodule

// File: tb/tb_multi_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_multi_button_debouncer
//
// Directed bench for multi_button_debouncer with TICK_DIV=4, STABLE_TICKS=3,
// ACTIVE_LOW=1, CHANNELS=4, REPEAT_DELAY=5, REPEAT_RATE=2. Edge numbers below
// count CLOCK_50 rising edges since the most recent resetn release; ticks land
// on edges 4, 8, 12, ...
// -----------------------------------------------------------------------------
module tb_multi_button_debouncer;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic [3:0] btn_in;
  logic [3:0] btn_level, btn_press, btn_release;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int base        = 0;
  int press_cnt   [4];
  int release_cnt [4];
  int snap;

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int         EXP_REPEATS = 5;
  localparam logic [3:0] EXP_REP_BIT = 4'b0001;
`else
  localparam int         EXP_REPEATS = 0;
  localparam logic [3:0] EXP_REP_BIT = 4'b0000;
`endif

  multi_button_debouncer #(
    .CHANNELS    (4),
    .TICK_DIV    (4),
    .STABLE_TICKS(3),
    .ACTIVE_LOW  (1),
    .REPEAT_DELAY(5),
    .REPEAT_RATE (2)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Strobe counters, sampled mid-cycle so each one-cycle pulse counts once.
  initial for (int i = 0; i < 4; i++) begin press_cnt[i] = 0; release_cnt[i] = 0; end
  always @(negedge CLOCK_50) begin
    for (int i = 0; i < 4; i++) begin
      press_cnt[i]   = press_cnt[i]   + int'(btn_press[i]);
      release_cnt[i] = release_cnt[i] + int'(btn_release[i]);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after rising edge n (relative to reset release).
  task automatic goto(input int n);
    while (cyc - base < n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  initial begin
    resetn = 1'b0;
    btn_in = 4'hF;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("reset_level",   btn_level,   4'h0);
    check("reset_press",   btn_press,   4'h0);
    check("reset_release", btn_release, 4'h0);
    resetn = 1'b1;
    base   = cyc;

    // 1. Clean press on ch0 after edge 2: disagreement from edge 5, ticks at
    //    8, 12, 16 -> level rises at edge 16 (14 edges after the drive).
    goto(2);  btn_in[0] = 1'b0;
    goto(15); check("p1_level_early", btn_level, 4'b0000);
    goto(16); check("p1_level",       btn_level, 4'b0001);
              check("p1_press",       btn_press, 4'b0001);
              check("p1_release",     btn_release, 4'b0000);
    goto(17); check("p1_press_width", btn_press, 4'b0000);
              check("p1_press_count", press_cnt[0], 1);

    // 2. Bounce on ch1: toggle every 3 cycles for 40 cycles, then hold low.
    for (int i = 0; i < 40; i++) begin
      goto(20 + i);
      if (i % 3 == 0) btn_in[1] = ~btn_in[1];
    end
    goto(60); btn_in[1] = 1'b0;
    goto(80); check("p2_level",         btn_level[1],   1'b1);
              check("p2_press_count",   press_cnt[1],   1);
              check("p2_release_count", release_cnt[1], 0);

    // 3. Glitch: ch2 pressed, then raw released for only 6 cycles (<= 2 ticks).
    btn_in[2] = 1'b0;
    goto(100); check("p3_pressed", btn_level[2], 1'b1);
               btn_in[2] = 1'b1;
    goto(106); btn_in[2] = 1'b0;
    goto(125); check("p3_level_held",    btn_level[2],   1'b1);
               check("p3_release_count", release_cnt[2], 0);

    // 4. Simultaneous channels. Release ch0 first, then press ch0+ch3 after
    //    edge 146: ticks 152, 156, 160 -> accepted at edge 160.
    btn_in[0] = 1'b1;
    goto(145); check("p4_ch0_released",  btn_level[0],   1'b0);
               check("p4_ch0_rel_count", release_cnt[0], 1);
    goto(146); btn_in = 4'b0000;
    goto(159); check("p4_level_early", btn_level, 4'b0110);
    goto(160); check("p4_level",       btn_level, 4'b1111);
               check("p4_press_pair",  btn_press & 4'b1001, 4'b1001);
    // Release both after edge 170: ticks 176, 180, 184.
    goto(170); btn_in = 4'b1001;
    goto(183); check("p4_rel_early",   btn_level, 4'b1111);
    goto(184); check("p4_rel_level",   btn_level, 4'b0110);
               check("p4_release_pair", btn_release, 4'b1001);
               check("p4_no_press",    btn_press & 4'b1001, 4'b0000);

    // 5. Reset mid-hold. Press ch0 after edge 190 (accepted at edge 204).
    goto(190); btn_in[0] = 1'b0;
    goto(210); check("p5_held", btn_level, 4'b0111);
    resetn = 1'b0;
    #1;
    check("p5_rst_level",   btn_level,   4'h0);
    check("p5_rst_press",   btn_press,   4'h0);
    check("p5_rst_release", btn_release, 4'h0);
    repeat (5) @(posedge CLOCK_50);
    #1;
    resetn = 1'b1;
    base   = cyc;
    // Held inputs reach sync2 at edge 2, disagree from edge 3, ticks 4, 8, 12.
    goto(11); check("p5_new_early", btn_level, 4'b0000);
    goto(12); check("p5_new_level", btn_level, 4'b0111);
              check("p5_new_press", btn_press & 4'b0111, 4'b0111);

    // 6. Hold ch0: repeats (if built in) at edges 32, 40, 48, 56, 64.
    goto(13); snap = press_cnt[0];
    goto(31); check("p6_pre_repeat",   btn_press & 4'b0001, 4'b0000);
    goto(32); check("p6_first_repeat", btn_press & 4'b0001, EXP_REP_BIT);
    goto(71); check("p6_repeat_count", press_cnt[0] - snap, EXP_REPEATS);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
